router_fsm: RTL and testbench
=============================

// Module: router_fsm
// PURPOSE
//  Control FSM of the 1x3 router. It sits directly upstream of router_reg and drives
//  router_reg's state strobes: detect_add, lfd_state, ld_state, laf_state, full_state
//  and rst_int_reg. It decodes the destination port from the header, stalls the source
//  via busy, and asserts write_enb_reg toward the FIFO write path. It reacts to FIFO
//  full/empty, per-port soft resets and the parity/low-valid flags from router_reg.
// PARAMETERS
//  ADDR_W        2      width of header destination field din[1:0]
//  INVALID_ADDR  2'b11  destination code that is ignored; FSM stays in DECODE_ADDRESS
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst            in   1  synchronous reset, active low
//  pktvalid       in   1  source data valid; high for header+payload, low on parity byte
//  din            in   2  header address bits, sampled only in DECODE_ADDRESS
//  fifofull       in   1  full flag of the currently addressed FIFO
//  fifo_empty_0   in   1  FIFO 0 empty
//  fifo_empty_1   in   1  FIFO 1 empty
//  fifo_empty_2   in   1  FIFO 2 empty
//  soft_reset_0   in   1  FIFO 0 read-timeout soft reset
//  soft_reset_1   in   1  FIFO 1 read-timeout soft reset
//  soft_reset_2   in   1  FIFO 2 read-timeout soft reset
//  parity_done    in   1  from router_reg: parity byte captured
//  lowpktvalid    in   1  from router_reg: pktvalid fell while full
//  write_enb_reg  out  1  enable FIFO write of router_reg dout
//  detect_add     out  1  state == DECODE_ADDRESS
//  lfd_state      out  1  state == LOAD_FIRST_DATA
//  ld_state       out  1  state == LOAD_DATA
//  laf_state      out  1  state == LOAD_AFTER_FULL
//  full_state     out  1  state == FIFO_FULL_STATE
//  rst_int_reg    out  1  state == CHECK_PARITY_ERROR
//  busy           out  1  stall source; source must hold din/pktvalid while high
// BEHAVIOUR
//  - Moore FSM: one registered state and one registered 2-bit addr latch. All outputs are
//    combinational decodes of state, with zero cycles of latency from the state register.
//  - rst==0 at posedge: state<=DECODE_ADDRESS, addr<=0. After reset: detect_add=1, all other outputs 0.
//  - addr<=din when state==DECODE_ADDRESS && pktvalid && din!=INVALID_ADDR.
//  - sel_empty = fifo_empty_[addr] (live din in DECODE_ADDRESS). sel_srst = soft_reset_[addr].
//  - Transitions and outputs ("busy", "wen" = write_enb_reg):
//    DECODE_ADDRESS  busy=0 wen=0: pktvalid & din!=3 & empty[din] -> LOAD_FIRST_DATA;
//                    pktvalid & din!=3 & !empty[din] -> WAIT_TILL_EMPTY; else stay.
//    LOAD_FIRST_DATA busy=1 wen=0: -> LOAD_DATA (unconditional).
//    LOAD_DATA       busy=0 wen=1: fifofull -> FIFO_FULL_STATE; else !pktvalid -> LOAD_PARITY;
//                    else stay. fifofull takes priority over !pktvalid.
//    FIFO_FULL_STATE busy=1 wen=0: !fifofull -> LOAD_AFTER_FULL; else stay.
//    LOAD_AFTER_FULL busy=1 wen=1: parity_done -> DECODE_ADDRESS; else lowpktvalid ->
//                    LOAD_PARITY; else -> LOAD_DATA.
//    LOAD_PARITY     busy=1 wen=1: -> CHECK_PARITY_ERROR.
//    CHECK_PARITY_ERROR busy=1 wen=0: fifofull -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
//    WAIT_TILL_EMPTY busy=1 wen=0: sel_empty -> LOAD_FIRST_DATA; else stay.
//  - Soft reset: sel_srst==1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next
//    cycle. This overrides every other transition. addr is kept. Soft resets of unselected
//    ports are ignored.
//  - rst low mid-packet: state aborts to DECODE_ADDRESS at the same edge. No partial outputs.
//  - Illegal or unused state codes -> DECODE_ADDRESS.
//  - INVALID_ADDR header with pktvalid: no state change, addr not updated, busy stays 0.
// TESTING
//  1. rst=0 one cycle -> detect_add=1, busy=0, all other outputs 0.
//  2. din=2'b01, pktvalid=1, fifo_empty_1=1 -> DECODE_ADDRESS, then LFD (busy=1), then
//     LOAD_DATA for 14 cycles (wen=1). pktvalid=0 -> LOAD_PARITY, CHECK_PARITY_ERROR
//     (rst_int_reg=1 for 1 cycle), then DECODE_ADDRESS.
//  3. In LOAD_DATA assert fifofull=1 for 3 cycles -> full_state=1, busy=1, wen=0 for those
//     3 cycles. Then laf_state=1 for 1 cycle, then back to LOAD_DATA with parity_done=0 and
//     lowpktvalid=0.
//  4. din=2'b10, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY with busy=1. Set
//     fifo_empty_2=1 -> lfd_state=1 on the next cycle.
//  5. din=2'b11, pktvalid=1 for 4 cycles -> detect_add stays 1 and busy stays 0.
//  6. addr=0 in LOAD_DATA: soft_reset_1=1 -> no effect. Then soft_reset_0=1 -> detect_add=1
//     on the next cycle. Also: rst=0 in FIFO_FULL_STATE -> DECODE_ADDRESS next cycle.

Source files
------------

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: decodes the header destination, stalls the source via
// busy and strobes router_reg / FIFO write path. All outputs are decodes of the state register.
module router_fsm #(
  parameter int                ADDR_W       = 2,
  parameter logic [ADDR_W-1:0] INVALID_ADDR = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pktvalid,
  input  logic [ADDR_W-1:0] din,
  input  logic              fifofull,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              lowpktvalid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hdr_ok;
  logic              sel_empty;
  logic              sel_srst;

  function automatic logic port_sel(input logic [2:0] v, input logic [ADDR_W-1:0] a);
    logic r;
    case (a)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign hdr_ok    = pktvalid && (din != INVALID_ADDR);
  // In DECODE_ADDRESS the header is still on din, so empty is looked up with the live address.
  assign sel_empty = port_sel({fifo_empty_2, fifo_empty_1, fifo_empty_0},
                              (state_q == DECODE_ADDRESS) ? din : addr_q);
  assign sel_srst  = port_sel({soft_reset_2, soft_reset_1, soft_reset_0}, addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          addr_d  = din;
          state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifofull)       state_d = FIFO_FULL_STATE;
        else if (!pktvalid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifofull) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)      state_d = DECODE_ADDRESS;
        else if (lowpktvalid) state_d = LOAD_PARITY;
        else                  state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifofull ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A read-timeout on the port being served abandons the packet; the address is kept.
    if (state_q != DECODE_ADDRESS && sel_srst) state_d = DECODE_ADDRESS;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                         (state_q == LOAD_PARITY);
  assign busy          = (state_q == LOAD_FIRST_DATA) || (state_q == FIFO_FULL_STATE) ||
                         (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY) ||
                         (state_q == CHECK_PARITY_ERROR) || (state_q == WAIT_TILL_EMPTY);

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios followed by random traffic, every cycle
// compared against a phase-level model of the router control rules.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst, pktvalid, fifofull, parity_done, lowpktvalid;
  logic [1:0] din;
  logic [2:0] em, sr;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk(clk), .rst(rst), .pktvalid(pktvalid), .din(din), .fifofull(fifofull),
    .fifo_empty_0(em[0]), .fifo_empty_1(em[1]), .fifo_empty_2(em[2]),
    .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
    .parity_done(parity_done), .lowpktvalid(lowpktvalid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // Model phases of a packet's life in the router
  localparam int IDLE = 0, FIRST = 1, BODY = 2, STALL = 3, RESUME = 4, PAR = 5, CHK = 6, WAITQ = 7;
  // Per-phase source stall and FIFO write enable, straight from the behaviour table
  localparam logic [7:0] BUSY_OF = 8'b1111_1010;  // bit index = phase
  localparam logic [7:0] WEN_OF  = 8'b0011_0100;

  int         ph;
  int         maddr;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (phase %0d)", tag, got, exp, ph);
    end
  endtask

  function automatic logic [7:0] expect_vec(input int p);
    logic [7:0] v;
    v = {p == IDLE, p == FIRST, p == BODY, p == RESUME, p == STALL, p == CHK,
         BUSY_OF[p], WEN_OF[p]};
    return v;
  endfunction

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic cyc(input string tag);
    int nph, naddr;
    nph = ph;
    naddr = maddr;
    if (!rst) begin
      nph = IDLE;
      naddr = 0;
    end else begin
      if (ph == IDLE) begin
        if (pktvalid && din != 2'd3) begin
          naddr = din;
          nph = em[din] ? FIRST : WAITQ;
        end
      end else if (ph == FIRST) nph = BODY;
      else if (ph == BODY) nph = fifofull ? STALL : (!pktvalid ? PAR : BODY);
      else if (ph == STALL) nph = fifofull ? STALL : RESUME;
      else if (ph == RESUME) nph = parity_done ? IDLE : (lowpktvalid ? PAR : BODY);
      else if (ph == PAR) nph = CHK;
      else if (ph == CHK) nph = fifofull ? STALL : IDLE;
      else if (ph == WAITQ) nph = em[maddr] ? FIRST : WAITQ;
      if (ph != IDLE && sr[maddr]) nph = IDLE;
    end
    @(posedge clk);
    #1;
    ph = nph;
    maddr = naddr;
    chk(tag, {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
              busy, write_enb_reg}, expect_vec(ph));
  endtask

  task automatic idle_inputs();
    rst = 1'b1; pktvalid = 1'b0; din = 2'd0; fifofull = 1'b0;
    em = 3'b111; sr = 3'b000; parity_done = 1'b0; lowpktvalid = 1'b0;
  endtask

  initial begin
    ph = IDLE;
    maddr = 0;
    idle_inputs();
    #2;
    rst = 1'b0;
    cyc("reset");
    rst = 1'b1;
    cyc("post_reset_idle");

    // Normal packet to port 1
    din = 2'd1; pktvalid = 1'b1;
    cyc("p1_lfd");
    cyc("p1_ld_enter");
    repeat (14) cyc("p1_ld_body");
    pktvalid = 1'b0;
    cyc("p1_parity");
    cyc("p1_check");
    cyc("p1_back_idle");

    // FIFO full in the middle of a packet to port 0
    din = 2'd0; pktvalid = 1'b1;
    cyc("full_lfd");
    cyc("full_ld");
    fifofull = 1'b1;
    repeat (3) cyc("full_stall");
    fifofull = 1'b0;
    cyc("full_laf");
    cyc("full_back_ld");
    pktvalid = 1'b0;
    cyc("full_parity");
    cyc("full_check");
    cyc("full_idle");

    // Destination 2 busy, then drains
    din = 2'd2; pktvalid = 1'b1; em = 3'b011;
    repeat (5) cyc("wait_empty");
    em = 3'b111;
    cyc("wait_to_lfd");
    sr = 3'b100;
    cyc("srst_from_lfd");
    sr = 3'b000;

    // Invalid header is ignored
    din = 2'd3;
    repeat (4) cyc("invalid_addr");

    // Soft reset of another port is ignored; of the active port aborts
    din = 2'd0;
    cyc("sr_lfd");
    cyc("sr_ld");
    sr = 3'b010;
    cyc("sr_other_port");
    sr = 3'b001;
    cyc("sr_own_port");
    sr = 3'b000;

    // Hard reset while stalled on full
    cyc("rst_lfd");
    cyc("rst_ld");
    fifofull = 1'b1;
    cyc("rst_full");
    rst = 1'b0;
    cyc("rst_in_full");
    idle_inputs();
    cyc("rst_release");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) != 0);
      pktvalid    = ($urandom_range(0, 4) != 0);
      din         = 2'($urandom_range(0, 3));
      fifofull    = ($urandom_range(0, 4) == 0);
      em          = 3'($urandom_range(0, 7));
      sr          = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 29) == 0)};
      parity_done = ($urandom_range(0, 7) == 0);
      lowpktvalid = ($urandom_range(0, 7) == 0);
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
